fetch_pc_gen: RTL
=================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning width of all addresses.
REQ-002 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_1000, meaning first fetch address after reset.
REQ-003 SHALL have parameter INST_BYTES, default 4, meaning sequential PC increment.
REQ-004 SHALL have ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- pc_if  output  ADDR_WIDTH  current fetch PC, driven to the branch target buffer lookup.
- btb_hit  input  1  BTB hit for pc_if, same cycle.
- btb_target  input  ADDR_WIDTH  BTB predicted target for pc_if, same cycle.
- redirect_valid  input  1  EX-stage mispredict/redirect request.
- redirect_pc  input  ADDR_WIDTH  corrected fetch address from EX.
- req_valid  output  1  I-cache request valid.
- req_addr  output  ADDR_WIDTH  I-cache request address; always equals pc_if.
- req_ready  input  1  I-cache accepts request.
- out_valid  output  1  fetch record valid to decode.
- out_pc  output  ADDR_WIDTH  PC of fetch record.
- out_pred_taken  output  1  BTB predicted taken for out_pc.
- out_pred_target  output  ADDR_WIDTH  predicted target; 0 when not taken.
- out_ready  input  1  decode accepts fetch record.
- redirect_count  output  32  number of redirects taken since reset.

Function
REQ-005 SHALL implement states BOOT, RUN, HOLD in a registered FSM.
REQ-006 SHALL be in BOOT for exactly one cycle after reset deassertion, with req_valid=0, then enter RUN.
REQ-007 SHALL drive req_valid=1 in RUN and req_valid=0 in BOOT and HOLD.
REQ-008 SHALL treat a request as accepted when req_valid and req_ready are both 1 at a posedge.
REQ-009 SHALL, on acceptance, load the output register: out_valid=1, out_pc=pc_if, out_pred_taken=btb_hit, out_pred_target=btb_hit?btb_target:0.
REQ-010 SHALL, on acceptance, update PC to btb_target if btb_hit, else to pc_if+INST_BYTES, modulo 2^ADDR_WIDTH (wrap, no flag).
REQ-011 SHALL hold PC unchanged when req_valid=1 and req_ready=0.
REQ-012 SHALL clear out_valid when out_valid and out_ready are both 1 and no new acceptance occurs in the same cycle; simultaneous consume and accept SHALL replace the record (zero-bubble throughput).
REQ-013 SHALL transition RUN->HOLD when out_valid=1 and out_ready=0 at the posedge, and SHALL not accept a new request in that cycle.
REQ-014 SHALL keep out_* stable while in HOLD, and return HOLD->RUN in the cycle after out_ready=1 is sampled.
REQ-015 SHALL give redirect_valid priority over all other events in any state except BOOT: PC<=redirect_pc with the low log2(INST_BYTES) bits forced to 0, out_valid<=0, any same-cycle acceptance discarded (no output load), state<=RUN.
REQ-016 SHALL, for redirect_valid during BOOT, load PC<=redirect_pc (aligned) and still complete BOOT normally.
REQ-017 SHALL increment redirect_count by 1 on every cycle redirect_valid=1 (not in reset), wrapping from 2^32-1 to 0.
REQ-018 SHALL have a combinational path only from btb_hit/btb_target to the PC/output-register next-state logic; no output SHALL depend combinationally on redirect_valid, req_ready or out_ready.

Reset
REQ-019 SHALL, while reset=0, asynchronously force: state=BOOT, PC=RESET_PC, out_valid=0, out_pc=0, out_pred_taken=0, out_pred_target=0, redirect_count=0.
REQ-020 SHALL, on reset assertion mid-operation, discard any pending record and in-flight request with no further handshake.

Verification
REQ-021 Bench SHALL cover: reset release, req_ready=1, btb_hit=0 -> req_addr 0x1000 then 0x1004, 0x1008 on consecutive cycles after one BOOT cycle.
REQ-022 Bench SHALL cover: pc_if=0x1008, btb_hit=1, btb_target=0x2000, accept -> out_pc=0x1008, out_pred_taken=1, out_pred_target=0x2000; next req_addr=0x2000.
REQ-023 Bench SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> HOLD, req_valid=0, out_* unchanged; out_ready=1 -> record consumed, req_valid=1 the following cycle.
REQ-024 Bench SHALL cover: redirect_valid=1, redirect_pc=0x3002 in the same cycle as an acceptance -> out_valid=0 next cycle, req_addr=0x3000, redirect_count increments by 1.
REQ-025 Bench SHALL cover: PC=2^64-4, btb_hit=0, accept -> next req_addr=0; and redirect_count preloaded via 2^32 redirects (or forced) wraps to 0.
REQ-026 Bench SHALL cover: reset asserted while in HOLD -> out_valid=0 and PC=0x1000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential/BTB-predicted next PC, I-cache request handshake,
// single-entry fetch record register toward decode, and EX redirect handling.
module fetch_pc_gen #(
   parameter int unsigned            ADDR_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(64'h0000_0000_0000_1000),
   parameter int unsigned            INST_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] pc_if,
   input  logic                  btb_hit,
   input  logic [ADDR_WIDTH-1:0] btb_target,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  req_valid,
   output logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_ready,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic                  out_pred_taken,
   output logic [ADDR_WIDTH-1:0] out_pred_target,
   input  logic                  out_ready,
   output logic [31:0]           redirect_count
);

   localparam int unsigned ALIGN_BITS = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 0;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));

   typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
   logic                  out_taken_q, out_taken_d;
   logic [ADDR_WIDTH-1:0] out_target_q, out_target_d;
   logic [31:0]           cnt_q, cnt_d;

   logic                  stall;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] redirect_aligned;

   // A pending record that decode refuses blocks acceptance, so the record is never overwritten.
   assign stall            = out_valid_q && !out_ready;
   assign accept           = (state_q == StRun) && req_ready && !stall;
   assign redirect_aligned = redirect_pc & ALIGN_MASK;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StBoot;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StBoot:  state_d = StRun;
         StRun: begin
            if (redirect_valid)  state_d = StRun;
            else if (stall)      state_d = StHold;
         end
         StHold: begin
            if (redirect_valid || out_ready) state_d = StRun;
         end
         default: state_d = StBoot;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_valid = (state_q == StRun);
   end

   // Datapath next-state: redirect wins over consume/accept outside BOOT.
   always_comb begin
      pc_d         = pc_q;
      out_valid_d  = out_valid_q;
      out_pc_d     = out_pc_q;
      out_taken_d  = out_taken_q;
      out_target_d = out_target_q;
      cnt_d        = cnt_q + 32'(redirect_valid);

      if (state_q == StBoot) begin
         if (redirect_valid) pc_d = redirect_aligned;
      end else if (redirect_valid) begin
         pc_d        = redirect_aligned;
         out_valid_d = 1'b0;
      end else begin
         if (out_valid_q && out_ready) out_valid_d = 1'b0;
         if (accept) begin
            out_valid_d  = 1'b1;
            out_pc_d     = pc_q;
            out_taken_d  = btb_hit;
            out_target_d = btb_hit ? btb_target : '0;
            pc_d         = btb_hit ? btb_target : pc_q + ADDR_WIDTH'(INST_BYTES);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q         <= RESET_PC;
         out_valid_q  <= 1'b0;
         out_pc_q     <= '0;
         out_taken_q  <= 1'b0;
         out_target_q <= '0;
         cnt_q        <= '0;
      end else begin
         pc_q         <= pc_d;
         out_valid_q  <= out_valid_d;
         out_pc_q     <= out_pc_d;
         out_taken_q  <= out_taken_d;
         out_target_q <= out_target_d;
         cnt_q        <= cnt_d;
      end
   end

   assign pc_if           = pc_q;
   assign req_addr        = pc_q;
   assign out_valid       = out_valid_q;
   assign out_pc          = out_pc_q;
   assign out_pred_taken  = out_taken_q;
   assign out_pred_target = out_target_q;
   assign redirect_count  = cnt_q;

endmodule
